// File: rtl/ysyx_icache.sv
// Direct-mapped, register-based instruction cache. Hits complete in the request cycle;
// misses refill a 4-word line through sequential single-word bus reads.
module ysyx_icache #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SET_BITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_pc,
   input  logic              ifu_req,
   output logic [DATA_W-1:0] ifu_inst_o,
   output logic              ifu_valid_o,
   input  logic              fence_i,
   output logic [ADDR_W-1:0] bus_araddr_o,
   output logic              bus_arvalid_o,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rvalid,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_W - 4 - SET_BITS;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [SETS-1:0]     valid_r;
   logic [TAG_W-1:0]    tag_r  [SETS];
   logic [DATA_W-1:0]   data_r [SETS][4];
   logic [ADDR_W-1:0]   fill_addr_r;
   logic [1:0]          cnt_r;
   logic                fence_pend_r;
   logic [31:0]         hit_cnt_r;
   logic [31:0]         miss_cnt_r;

   logic [SET_BITS-1:0] index_s;
   logic [SET_BITS-1:0] fill_index_s;
   logic [1:0]          offset_s;
   logic [TAG_W-1:0]    tag_s;
   logic                hit_s;
   logic                miss_s;
   logic                beat_s;
   logic                fill_done_s;
   logic                unused_s;

   assign index_s      = ifu_pc[3+SET_BITS:4];
   assign offset_s     = ifu_pc[3:2];
   assign tag_s        = ifu_pc[ADDR_W-1:4+SET_BITS];
   assign fill_index_s = fill_addr_r[3+SET_BITS:4];
   assign unused_s     = ^ifu_pc[1:0];
   assign hit_cnt_o    = hit_cnt_r;
   assign miss_cnt_o   = miss_cnt_r;

   // Lookup, next-state and bus/IFU outputs
   always_comb begin
      state_nxt_s   = state_r;
      hit_s         = 1'b0;
      miss_s        = 1'b0;
      beat_s        = 1'b0;
      fill_done_s   = 1'b0;
      ifu_valid_o   = 1'b0;
      ifu_inst_o    = {DATA_W{1'b0}};
      bus_arvalid_o = 1'b0;
      bus_araddr_o  = {ADDR_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (ifu_req && valid_r[index_s] && (tag_r[index_s] == tag_s) && !fence_i) begin
               hit_s       = 1'b1;
               ifu_valid_o = 1'b1;
               ifu_inst_o  = data_r[index_s][offset_s];
            end else if (ifu_req) begin
               miss_s      = 1'b1;
               state_nxt_s = FILL;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FILL: begin
            bus_arvalid_o = 1'b1;
            bus_araddr_o  = fill_addr_r + {{(ADDR_W-4){1'b0}}, cnt_r, 2'b00};
            beat_s        = bus_rvalid;
            if (bus_rvalid && (cnt_r == 2'd3)) begin
               fill_done_s = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FILL;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Valid bits, fill bookkeeping, deferred fence and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r      <= {SETS{1'b0}};
         fill_addr_r  <= {ADDR_W{1'b0}};
         cnt_r        <= 2'd0;
         fence_pend_r <= 1'b0;
         hit_cnt_r    <= 32'd0;
         miss_cnt_r   <= 32'd0;
      end else begin
         if (hit_s) begin
            hit_cnt_r <= hit_cnt_r + 32'd1;
         end
         if (miss_s) begin
            miss_cnt_r  <= miss_cnt_r + 32'd1;
            fill_addr_r <= {ifu_pc[ADDR_W-1:4], 4'b0000};
            cnt_r       <= 2'd0;
         end else if (beat_s) begin
            cnt_r <= cnt_r + 2'd1;
         end
         // A fence seen during the fill also wipes the line just installed
         if (fill_done_s) begin
            fence_pend_r <= 1'b0;
            if (fence_pend_r || fence_i) begin
               valid_r <= {SETS{1'b0}};
            end else begin
               valid_r[fill_index_s] <= 1'b1;
            end
         end else if ((state_r == FILL) && fence_i) begin
            fence_pend_r <= 1'b1;
         end else if ((state_r == IDLE) && fence_i) begin
            valid_r <= {SETS{1'b0}};
         end
      end
   end

   // Line storage; contents are only ever read behind a set valid bit
   always_ff @(posedge clk) begin
      if (!rst && beat_s) begin
         data_r[fill_index_s][cnt_r] <= bus_rdata;
      end
      if (!rst && fill_done_s) begin
         tag_r[fill_index_s] <= fill_addr_r[ADDR_W-1:4+SET_BITS];
      end
   end

endmodule

// File: doc/ysyx_icache.md
# ysyx_icache

Direct-mapped instruction cache between the IFU and the bus arbiter's IFU read port. It serves fetches from register-based tag/data arrays on a hit with zero added latency. On a miss it refills one 16-byte line through four sequential single-word reads on the arbiter's `ifu_araddr`/`ifu_arvalid`/`ifu_rdata_o`/`ifu_rvalid_o` channel. A `fence_i` input invalidates the whole cache.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: word width.
- `SET_BITS`, 4: log2 of the number of sets (default 16 sets). Line is fixed at 4 words / 16 bytes.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_pc` in ADDR_W: fetch address. Bits [1:0] are ignored.
- `ifu_req` in 1: fetch request. Held with a stable `ifu_pc` until `ifu_valid_o`.
- `ifu_inst_o` out DATA_W: fetched instruction. Valid only with `ifu_valid_o`; 0 otherwise.
- `ifu_valid_o` out 1: fetch complete (1-cycle pulse per served request cycle).
- `fence_i` in 1: invalidate all lines (1-cycle pulse).
- `bus_araddr_o` out ADDR_W: word address to the arbiter's `ifu_araddr`.
- `bus_arvalid_o` out 1: to the arbiter's `ifu_arvalid`.
- `bus_rdata` in DATA_W: from the arbiter's `ifu_rdata_o`.
- `bus_rvalid` in 1: from the arbiter's `ifu_rvalid_o`.
- `hit_cnt_o` out 32: hit counter. Wraps at 2^32.
- `miss_cnt_o` out 32: miss counter. Wraps at 2^32.

## Operation
- Address split:
  - offset = `pc[3:2]` (word in line)
  - index = `pc[3+SET_BITS:4]`
  - tag = `pc[ADDR_W-1:4+SET_BITS]`
- Storage per set: valid bit, tag, 4 data words. All registers.
- **IDLE**
  - hit = `ifu_req & valid[index] & tag match & !fence_i`.
  - On a hit: `ifu_valid_o`=1 and `ifu_inst_o`=data[index][offset] combinationally in the same cycle; `hit_cnt_o`+1.
  - On `ifu_req` & miss: latch line base `{pc[ADDR_W-1:4],4'b0}` into `fill_addr`, clear `cnt`, go to FILL; `miss_cnt_o`+1.
  - A miss is counted once per fill, not once per waiting cycle.
- **FILL**
  - `bus_arvalid_o`=1 and `bus_araddr_o`=`fill_addr`+4*`cnt` for the whole state, including the cycle in which `bus_rvalid` arrives.
  - On `bus_rvalid`: write data[fill_index][cnt] = `bus_rdata`, then `cnt`+1.
  - On `bus_rvalid` with `cnt`==3: write the word, set valid and tag, go to IDLE.
  - `ifu_valid_o`=0 throughout FILL. The request is re-looked-up in IDLE on the next cycle and hits.
- **fence_i**
  - In IDLE: all valid bits clear at the clock edge; a hit in that same cycle is suppressed.
  - In FILL: latched as pending. The fill finishes, then all valid bits (including the new line) clear on the cycle of the IDLE transition.
- **Request changes mid-fill:** the fill always completes for the latched `fill_addr`. It is not aborted by a changed `ifu_pc` or a dropped `ifu_req`.
- `bus_rvalid` outside FILL is ignored.
- Outputs are 0 whenever not active: `bus_araddr_o`=0 outside FILL.

## Timing
- Reset: state=IDLE, all valid=0, `cnt`=0, pending fence=0, `hit_cnt_o`=`miss_cnt_o`=0, `bus_arvalid_o`=0, `bus_araddr_o`=0, `ifu_valid_o`=0, `ifu_inst_o`=0.
- `rst` asserted mid-fill: abort, line stays invalid, and `bus_arvalid_o` is 0 in the next cycle.
- Hit latency: 0 cycles (same cycle as `ifu_req`). Sustained throughput is 1 fetch/cycle on hits.
- Miss latency: 1 cycle (IDLE→FILL) + sum of 4 bus word latencies + 1 cycle (re-lookup hit).
- With a bus that returns `rvalid` one cycle after `arvalid`, the miss completes in 1 + 4×2 + 1 = 10 cycles.
- Handshake: `bus_arvalid_o` never deasserts inside FILL before the 4th `bus_rvalid`. The address advances only on the cycle after each `bus_rvalid`.
- Counters update on the clock edge after the event.

## Test plan
- **Cold miss then hits:** reset, `ifu_req` at pc=0x80000000 with bus data 0x11,0x22,0x33,0x44 for 0x80000000..C.
  - Exactly 4 bus reads at +0,+4,+8,+C, then `ifu_inst_o`=0x11.
  - Subsequent pcs 0x80000004/8/C hit at 0 latency with 0x22/0x33/0x44.
  - `miss_cnt_o`=1, `hit_cnt_o`=4.
- **Conflict eviction:** fill 0x80000000, then fetch 0x80000100 (same index, different tag).
  - Result is a miss and refill.
  - Refetching 0x80000000 misses again; `miss_cnt_o`=3.
- **Fence:** fill a line, pulse `fence_i` in IDLE, refetch the same pc.
  - Refetch misses.
  - Pulsing `fence_i` during FILL: the fill completes (4 reads), then the re-lookup misses again.
- **Bus stalls:** `bus_rvalid` delayed 0–7 random cycles per word.
  - `bus_arvalid_o` stays high through FILL with a stable address between beats.
  - Data is correct.
  - `ifu_valid_o` is never asserted during FILL.
- **Reset mid-fill:** assert `rst` after the 2nd beat.
  - All outputs are 0 next cycle.
  - Refetching the same pc performs a full 4-beat fill.
- **pc change mid-fill:** switch `ifu_pc` to a different line during FILL.
  - The original line completes.
  - The new pc then misses and fills its own line; the first line remains valid.
